// File: rtl/cus42_pkg.sv
// Shared timing constants, CPU register map and write-field decode for the
// CUS42 tilemap fetch block.
package cus42_pkg;

  localparam int H_TOTAL       = 384;
  localparam int V_TOTAL       = 264;
  localparam int H_BLANK_START = 288;
  localparam int H_SYNC_START  = 304;
  localparam int H_SYNC_END    = 335;
  localparam int V_BLANK_START = 224;
  localparam int V_SYNC_START  = 240;
  localparam int V_SYNC_END    = 242;

  localparam logic [2:0] CA_SXL_A = 3'd0;
  localparam logic [2:0] CA_SXH_A = 3'd1;
  localparam logic [2:0] CA_SY_A  = 3'd2;
  localparam logic [2:0] CA_SXL_B = 3'd4;
  localparam logic [2:0] CA_SXH_B = 3'd5;
  localparam logic [2:0] CA_SY_B  = 3'd6;

  typedef enum logic [1:0] {
    FLD_SXL  = 2'd0,
    FLD_SXH  = 2'd1,
    FLD_SY   = 2'd2,
    FLD_NONE = 2'd3
  } field_e;

  function automatic field_e ca_field(input logic [2:0] ca);
    case (ca)
      CA_SXL_A, CA_SXL_B: ca_field = FLD_SXL;
      CA_SXH_A, CA_SXH_B: ca_field = FLD_SXH;
      CA_SY_A,  CA_SY_B:  ca_field = FLD_SY;
      default:            ca_field = FLD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cus42_scroll_layer.sv
// One scroll layer: shadow/active scroll registers and the effective x/y
// coordinate for the position the counters are about to reach.
module cus42_scroll_layer
  import cus42_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       wr_en,
  input  logic [1:0] wr_field,
  input  logic [7:0] wr_data,
  input  logic       xfer,
  input  logic       flip,
  input  logic [8:0] hpos,
  input  logic [7:0] vpos,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] fx
);

  logic [8:0] sx_shadow_q, sx_shadow_d, sx_q, sx_d;
  logic [7:0] sy_shadow_q, sy_shadow_d, sy_q, sy_d;
  logic [8:0] x_raw;
  logic [7:0] y_raw;

  always_comb begin
    sx_shadow_d = sx_shadow_q;
    sy_shadow_d = sy_shadow_q;
    if (wr_en) begin
      case (field_e'(wr_field))
        FLD_SXL: sx_shadow_d[7:0] = wr_data;
        FLD_SXH: sx_shadow_d[8]   = wr_data[0];
        FLD_SY:  sy_shadow_d      = wr_data;
        default: ;
      endcase
    end
    // Transfer reads the pre-write shadow, so a same-cycle write waits a line.
    sx_d = xfer ? sx_shadow_q : sx_q;
    sy_d = xfer ? sy_shadow_q : sy_q;
    if (srst) begin
      sx_shadow_d = '0;
      sy_shadow_d = '0;
      sx_d        = '0;
      sy_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    sx_shadow_q <= sx_shadow_d;
    sy_shadow_q <= sy_shadow_d;
    sx_q        <= sx_d;
    sy_q        <= sy_d;
  end

  // 511-x and 255-y are plain bit inversions at these widths.
  always_comb begin
    x_raw = hpos + 9'd8 + sx_d;
    y_raw = vpos + sy_d;
    x     = flip ? ~x_raw : x_raw;
    y     = flip ? ~y_raw : y_raw;
    fx    = flip ? ~sx_d[2:0] : sx_d[2:0];
  end

endmodule

// File: rtl/cus42_fetch.sv
// CUS42 tilemap fetch: video counters, timing, CPU scroll registers and the
// per-slot tile RAM / graphics ROM address generation for layers A and B.
module cus42_fetch
  import cus42_pkg::*;
(
  input  logic        CLK_6M,
  input  logic        RST,
  input  logic        FLIP,
  input  logic        CS,
  input  logic        nWE,
  input  logic [2:0]  CA,
  input  logic [7:0]  CD,
  output logic [11:0] RA,
  output logic [2:0]  GROW,
  output logic        GHALF,
  output logic        CLK_2H,
  output logic        HA2,
  output logic        HB2,
  output logic [2:0]  FXA,
  output logic [2:0]  FXB,
  output logic        HBLANK,
  output logic        VBLANK,
  output logic        HSYNC,
  output logic        VSYNC
);

  logic [8:0] hcount_q, hcount_d;
  logic [8:0] vcount_q, vcount_d;
  logic       flip_q, flip_d;
  logic       xfer;
  logic       wr;
  field_e     wr_field;

  logic [1:0][8:0] lx;
  logic [1:0][7:0] ly;
  logic [1:0][2:0] lfx;

  logic [11:0] ra_q, ra_d;
  logic [2:0]  grow_q, grow_d;
  logic        ghalf_q, ghalf_d, clk2h_q, clk2h_d, hs2_q, hs2_d;
  logic [2:0]  fxa_q, fxa_d, fxb_q, fxb_d;
  logic        hblank_q, hblank_d, vblank_q, vblank_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        sel;

  assign xfer     = (hcount_q == 9'(H_TOTAL - 1));
  assign wr       = CS & ~nWE;
  assign wr_field = ca_field(CA);

  always_comb begin
    hcount_d = xfer ? 9'd0 : hcount_q + 9'd1;
    vcount_d = vcount_q;
    flip_d   = flip_q;
    if (xfer) begin
      vcount_d = (vcount_q == 9'(V_TOTAL - 1)) ? 9'd0 : vcount_q + 9'd1;
      if (vcount_q == 9'(V_TOTAL - 1)) flip_d = FLIP;
    end
    if (RST) begin
      hcount_d = '0;
      vcount_d = '0;
      flip_d   = 1'b0;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_layer
    cus42_scroll_layer u_layer (
      .clk      (CLK_6M),
      .srst     (RST),
      .wr_en    (wr && (CA[2] == 1'(gi)) && (wr_field != FLD_NONE)),
      .wr_field (wr_field),
      .wr_data  (CD),
      .xfer     (xfer),
      .flip     (flip_d),
      .hpos     (hcount_d),
      .vpos     (vcount_d[7:0]),
      .x        (lx[gi]),
      .y        (ly[gi]),
      .fx       (lfx[gi])
    );
  end

  // Outputs are computed from the next counter values so they line up with
  // hcount/vcount in the cycle they are presented.
  always_comb begin
    sel      = hcount_d[1];
    ra_d     = {sel, ly[sel][7:3], lx[sel][8:3]};
    grow_d   = ly[sel][2:0];
    ghalf_d  = hcount_d[2];
    clk2h_d  = hcount_d[1];
    hs2_d    = (hcount_d[2:0] == 3'd7);
    fxa_d    = lfx[0];
    fxb_d    = lfx[1];
    hblank_d = (hcount_d >= 9'(H_BLANK_START));
    hsync_d  = (hcount_d >= 9'(H_SYNC_START)) && (hcount_d <= 9'(H_SYNC_END));
    vblank_d = (vcount_d >= 9'(V_BLANK_START));
    vsync_d  = (vcount_d >= 9'(V_SYNC_START)) && (vcount_d <= 9'(V_SYNC_END));
    if (RST) begin
      ra_d     = '0;
      grow_d   = '0;
      ghalf_d  = 1'b0;
      clk2h_d  = 1'b0;
      hs2_d    = 1'b0;
      fxa_d    = '0;
      fxb_d    = '0;
      hblank_d = 1'b0;
      hsync_d  = 1'b0;
      vblank_d = 1'b0;
      vsync_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK_6M) begin
    hcount_q <= hcount_d;
    vcount_q <= vcount_d;
    flip_q   <= flip_d;
    ra_q     <= ra_d;
    grow_q   <= grow_d;
    ghalf_q  <= ghalf_d;
    clk2h_q  <= clk2h_d;
    hs2_q    <= hs2_d;
    fxa_q    <= fxa_d;
    fxb_q    <= fxb_d;
    hblank_q <= hblank_d;
    hsync_q  <= hsync_d;
    vblank_q <= vblank_d;
    vsync_q  <= vsync_d;
  end

  assign RA     = ra_q;
  assign GROW   = grow_q;
  assign GHALF  = ghalf_q;
  assign CLK_2H = clk2h_q;
  assign HA2    = hs2_q;
  assign HB2    = hs2_q;
  assign FXA    = fxa_q;
  assign FXB    = fxb_q;
  assign HBLANK = hblank_q;
  assign VBLANK = vblank_q;
  assign HSYNC  = hsync_q;
  assign VSYNC  = vsync_q;

endmodule

// File: tb/tb_cus42_fetch.sv
// Directed testbench for cus42_fetch; the bench tracks its own hcount/vcount
// model and checks outputs 1 time unit after each rising edge.
module tb_cus42_fetch;

  logic        CLK_6M = 1'b0;
  logic        RST = 1'b1;
  logic        FLIP = 1'b0;
  logic        CS = 1'b0;
  logic        nWE = 1'b1;
  logic [2:0]  CA = '0;
  logic [7:0]  CD = '0;
  logic [11:0] RA;
  logic [2:0]  GROW, FXA, FXB;
  logic        GHALF, CLK_2H, HA2, HB2, HBLANK, VBLANK, HSYNC, VSYNC;

  int checks = 0;
  int passes = 0;
  int tb_h = 0;
  int tb_v = 0;

  always #5 CLK_6M = ~CLK_6M;

  cus42_fetch dut (
    .CLK_6M (CLK_6M), .RST (RST), .FLIP (FLIP), .CS (CS), .nWE (nWE),
    .CA (CA), .CD (CD), .RA (RA), .GROW (GROW), .GHALF (GHALF),
    .CLK_2H (CLK_2H), .HA2 (HA2), .HB2 (HB2), .FXA (FXA), .FXB (FXB),
    .HBLANK (HBLANK), .VBLANK (VBLANK), .HSYNC (HSYNC), .VSYNC (VSYNC)
  );

  task automatic tick();
    @(posedge CLK_6M);
    #1;
    if (tb_h == 383) begin
      tb_h = 0;
      tb_v = (tb_v == 263) ? 0 : tb_v + 1;
    end else begin
      tb_h++;
    end
  endtask

  task automatic go_to(input int h, input int v);
    int budget;
    budget = 0;
    while (!(tb_h == h && tb_v == v) && budget < 120000) begin
      tick();
      budget++;
    end
    checks++;
    if (budget >= 120000) $display("FAIL go_to_timeout target h=%0d v=%0d not reached", h, v);
    else passes++;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    CS = 1'b1; nWE = 1'b0; CA = a; CD = d;
    tick();
    CS = 1'b0; nWE = 1'b1;
  endtask

  task automatic test_reset();
    logic [28:0] outs;
    RST = 1'b1;
    CS = 1'b1; nWE = 1'b0; CA = 3'd0; CD = 8'h55;
    repeat (3) @(posedge CLK_6M);
    #1;
    CS = 1'b0; nWE = 1'b1;
    outs = {RA, GROW, GHALF, CLK_2H, HA2, HB2, FXA, FXB, HBLANK, VBLANK, HSYNC, VSYNC};
    checks++; if (outs !== 29'd0) $display("FAIL reset_outputs got %h exp 0", outs); else passes++;
    checks++; if (RA !== 12'h000) $display("FAIL reset_ra got %h exp 000", RA); else passes++;
    RST = 1'b0;
    tb_h = 0; tb_v = 0;
    tick();
    // h=1, scroll 0 (write under reset discarded): x=9 tx=1, y=0
    checks++; if (RA !== 12'h001) $display("FAIL reset_first_ra got %h exp 001", RA); else passes++;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    go_to(0, 10);
    checks++; if (RA !== 12'h041) $display("FAIL basic_ra_s0 got %h exp 041", RA); else passes++;
    checks++; if (GROW !== 3'd2) $display("FAIL basic_grow got %0d exp 2", GROW); else passes++;
    checks++; if ({CLK_2H, GHALF} !== 2'b00) $display("FAIL basic_slot0 got %b exp 00", {CLK_2H, GHALF}); else passes++;
    go_to(2, 10);
    checks++; if (RA !== 12'h841) $display("FAIL basic_ra_s1 got %h exp 841", RA); else passes++;
    checks++; if ({CLK_2H, GHALF} !== 2'b10) $display("FAIL basic_slot1 got %b exp 10", {CLK_2H, GHALF}); else passes++;
    go_to(4, 10);
    checks++; if ({CLK_2H, GHALF} !== 2'b01) $display("FAIL basic_slot2 got %b exp 01", {CLK_2H, GHALF}); else passes++;
    $display("test_basic done");
  endtask

  task automatic test_scroll_x_511();
    go_to(100, 10);
    cpu_write(3'd0, 8'hFF);
    cpu_write(3'd1, 8'h01);
    go_to(120, 10);
    checks++; if (RA !== 12'h050) $display("FAIL sx511_same_line got %h exp 050", RA); else passes++;
    checks++; if (FXA !== 3'd0) $display("FAIL sx511_fxa_old got %0d exp 0", FXA); else passes++;
    go_to(0, 11);
    checks++; if (RA !== 12'h040) $display("FAIL sx511_next_line got %h exp 040", RA); else passes++;
    checks++; if (GROW !== 3'd3) $display("FAIL sx511_grow got %0d exp 3", GROW); else passes++;
    checks++; if (FXA !== 3'd7) $display("FAIL sx511_fxa got %0d exp 7", FXA); else passes++;
    $display("test_scroll_x_511 done");
  endtask

  task automatic test_tx_wrap();
    go_to(10, 11);
    cpu_write(3'd0, 8'hC8);
    cpu_write(3'd1, 8'h00);
    go_to(296, 12);
    checks++; if (RA !== 12'h07F) $display("FAIL wrap_tx63 got %h exp 07F", RA); else passes++;
    go_to(304, 12);
    checks++; if (RA !== 12'h040) $display("FAIL wrap_tx0 got %h exp 040", RA); else passes++;
    go_to(310, 12);
    cpu_write(3'd0, 8'h00);
    $display("test_tx_wrap done");
  endtask

  task automatic test_write_on_xfer();
    go_to(383, 13);
    cpu_write(3'd6, 8'h08);
    go_to(2, 14);
    checks++; if (RA !== 12'h841) $display("FAIL xfer_next_line got %h exp 841", RA); else passes++;
    go_to(2, 15);
    checks++; if (RA !== 12'h881) $display("FAIL xfer_line_after got %h exp 881", RA); else passes++;
    checks++; if (GROW !== 3'd7) $display("FAIL xfer_grow got %0d exp 7", GROW); else passes++;
    go_to(10, 15);
    cpu_write(3'd6, 8'h00);
    $display("test_write_on_xfer done");
  endtask

  task automatic test_frame_timing();
    int hb_err, hs_err, vb_err, vs_err, hp_err, vs_cnt, budget;
    logic [11:0] ra_263;
    hb_err = 0; hs_err = 0; vb_err = 0; vs_err = 0; hp_err = 0; vs_cnt = 0; budget = 0;
    ra_263 = '0;
    FLIP = 1'b1;
    while (!(tb_h == 0 && tb_v == 0) && budget < 120000) begin
      tick();
      budget++;
      if (HBLANK !== (tb_h >= 288)) hb_err++;
      if (HSYNC !== (tb_h >= 304 && tb_h <= 335)) hs_err++;
      if (VBLANK !== (tb_v >= 224)) vb_err++;
      if (VSYNC !== (tb_v >= 240 && tb_v <= 242)) vs_err++;
      if (HA2 !== (tb_h % 8 == 7) || HB2 !== HA2) hp_err++;
      if (VSYNC === 1'b1) vs_cnt++;
      if (tb_h == 0 && tb_v == 263) ra_263 = RA;
    end
    checks++; if (budget >= 120000) $display("FAIL frame_timeout got %0d cycles", budget); else passes++;
    checks++; if (hb_err !== 0) $display("FAIL hblank_errors got %0d exp 0", hb_err); else passes++;
    checks++; if (hs_err !== 0) $display("FAIL hsync_errors got %0d exp 0", hs_err); else passes++;
    checks++; if (vb_err !== 0) $display("FAIL vblank_errors got %0d exp 0", vb_err); else passes++;
    checks++; if (vs_err !== 0) $display("FAIL vsync_errors got %0d exp 0", vs_err); else passes++;
    checks++; if (hp_err !== 0) $display("FAIL ha2_hb2_errors got %0d exp 0", hp_err); else passes++;
    checks++; if (vs_cnt !== 1152) $display("FAIL vsync_cycles got %0d exp 1152", vs_cnt); else passes++;
    // Last line of the frame still uses the old (unflipped) FLIP.
    checks++; if (ra_263 !== 12'h001) $display("FAIL flip_not_early got %h exp 001", ra_263); else passes++;
    $display("test_frame_timing done");
  endtask

  task automatic test_flip();
    checks++; if (RA !== 12'h7FE) $display("FAIL flip_ra_a got %h exp 7FE", RA); else passes++;
    checks++; if (GROW !== 3'd7) $display("FAIL flip_grow got %0d exp 7", GROW); else passes++;
    checks++; if ({FXA, FXB} !== 6'o77) $display("FAIL flip_fx got %o exp 77", {FXA, FXB}); else passes++;
    checks++; if ({HBLANK, VBLANK} !== 2'b00) $display("FAIL flip_blank got %b exp 00", {HBLANK, VBLANK}); else passes++;
    go_to(2, 0);
    checks++; if (RA !== 12'hFFE) $display("FAIL flip_ra_b got %h exp FFE", RA); else passes++;
    $display("test_flip done");
  endtask

  task automatic test_mid_reset();
    logic [28:0] outs;
    int waited;
    go_to(200, 0);
    RST = 1'b1;
    tick();
    tb_h = 0; tb_v = 0;
    outs = {RA, GROW, GHALF, CLK_2H, HA2, HB2, FXA, FXB, HBLANK, VBLANK, HSYNC, VSYNC};
    checks++; if (outs !== 29'd0) $display("FAIL midreset_outputs got %h exp 0", outs); else passes++;
    RST = 1'b0;
    FLIP = 1'b0;
    tick();
    checks++; if (RA !== 12'h001) $display("FAIL midreset_h1_ra got %h exp 001", RA); else passes++;
    waited = 0;
    while (HA2 !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++; if (tb_h !== 7) $display("FAIL midreset_first_ha2 got h=%0d exp 7", tb_h); else passes++;
    $display("test_mid_reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scroll_x_511();
    test_tx_wrap();
    test_write_on_xfer();
    test_frame_timing();
    test_flip();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
